// File: rtl/iic_txn_scheduler_pkg.sv
// Shared types and constants for the IIC transaction scheduler and its arbiter.
package iic_pkg;

    localparam int IIC_WORD_WIDTH = 8;

    typedef enum logic [2:0] {IDLE, ARB, LOAD, SEND, WAIT, FIN} sched_state_t;

    // Index arithmetic modulo n without a divider; both operands are already < n.
    function automatic int wrap_add(input int a, input int b, input int n);
        int s;
        s = a + b;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/iic_txn_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr, wrapping.
module rr_arbiter
    import iic_pkg::*;
#(
    parameter int n_req     = 4,
    parameter int idx_width = $clog2(n_req)
) (
    input  logic [n_req-1:0]     req,
    input  logic [idx_width-1:0] ptr,
    output logic [n_req-1:0]     gnt,
    output logic [idx_width-1:0] idx,
    output logic                 valid
);

    logic [idx_width-1:0] sel;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        sel   = '0;
        for (int i = 0; i < n_req; i++) begin
            sel = idx_width'(wrap_add(int'(ptr), i, n_req));
            if (!valid && req[sel]) begin
                valid    = 1'b1;
                gnt[sel] = 1'b1;
                idx      = sel;
            end
        end
    end

endmodule

// File: rtl/iic_txn_scheduler.sv
// Shares one IIC byte engine between n_req requesters: round-robin grant of a multi-byte
// transaction, word streaming into the engine with a per-word timeout, and tagged receive forwarding.
module iic_txn_scheduler
    import iic_pkg::*;
#(
    parameter int word_width = IIC_WORD_WIDTH,
    parameter int n_req      = 4,
    parameter int len_width  = 4,
    parameter int timeout    = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [n_req-1:0]              REQ,
    input  logic [n_req*len_width-1:0]    REQ_LEN,
    input  logic [n_req-1:0]              TX_VALID,
    input  logic [n_req*word_width-1:0]   TX_DATA,
    output logic [n_req-1:0]              TX_READY,
    output logic [n_req-1:0]              GNT,
    output logic [n_req-1:0]              DONE,
    output logic                          ERR,
    output logic [word_width-1:0]         RX_DATA,
    output logic                          RX_VALID,
    output logic [$clog2(n_req)-1:0]      RX_ID,
    output logic                          ENG_WE,
    output logic [word_width-1:0]         ENG_D_IN,
    input  logic                          ENG_IN_READY,
    input  logic [word_width-1:0]         ENG_D_OUT,
    input  logic                          ENG_OUT_READY
);

    localparam int IW = $clog2(n_req);
    localparam int TW = $clog2(timeout + 1);
    localparam logic [TW-1:0] TMR_MAX = TW'(timeout);

    sched_state_t         state;
    logic [IW-1:0]        rr;
    logic [IW-1:0]        gnt_idx;
    logic [len_width-1:0] cnt;
    logic [TW-1:0]        tmr;
    logic [TW-1:0]        tmr_inc;
    logic                 out_ready_q;

    logic [n_req-1:0]     arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 arb_valid;

    logic [len_width-1:0]  req_len_a [n_req];
    logic [word_width-1:0] tx_data_a [n_req];

    always_comb begin
        for (int i = 0; i < n_req; i++) begin
            req_len_a[i] = REQ_LEN[i*len_width +: len_width];
            tx_data_a[i] = TX_DATA[i*word_width +: word_width];
        end
    end

    assign tmr_inc = (tmr == TMR_MAX) ? tmr : tmr + 1'b1;

    rr_arbiter #(.n_req(n_req), .idx_width(IW)) u_arb (
        .req   (REQ),
        .ptr   (rr),
        .gnt   (arb_gnt),
        .idx   (arb_idx),
        .valid (arb_valid)
    );

    // Transaction FSM; strobes default low so every pulse lasts exactly one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= '0;
            gnt_idx  <= '0;
            cnt      <= '0;
            tmr      <= '0;
            GNT      <= '0;
            TX_READY <= '0;
            DONE     <= '0;
            ERR      <= 1'b0;
            ENG_WE   <= 1'b0;
            ENG_D_IN <= '0;
        end else begin
            TX_READY <= '0;
            DONE     <= '0;
            ERR      <= 1'b0;
            ENG_WE   <= 1'b0;
            case (state)
                IDLE: if (|REQ) state <= ARB;
                ARB: begin
                    if (!arb_valid) begin
                        state <= IDLE;
                    end else begin
                        GNT     <= arb_gnt;
                        gnt_idx <= arb_idx;
                        cnt     <= req_len_a[arb_idx];
                        rr      <= (arb_idx == IW'(n_req - 1)) ? '0 : arb_idx + 1'b1;
                        state   <= (req_len_a[arb_idx] == '0) ? FIN : LOAD;
                    end
                end
                LOAD: begin
                    if (TX_VALID[gnt_idx] && ENG_IN_READY) begin
                        TX_READY <= GNT;
                        ENG_WE   <= 1'b1;
                        ENG_D_IN <= tx_data_a[gnt_idx];
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        tmr      <= '0;
                        state    <= SEND;
                    end
                end
                // The timer measures cycles since the word was handed over, across both phases.
                SEND, WAIT: begin
                    if (state == SEND && !ENG_IN_READY) begin
                        state <= WAIT;
                        tmr   <= tmr_inc;
                    end else if (state == WAIT && ENG_IN_READY) begin
                        state <= (cnt != '0) ? LOAD : FIN;
                    end else if (tmr == TMR_MAX) begin
                        ERR   <= 1'b1;
                        DONE  <= GNT;
                        GNT   <= '0;
                        state <= IDLE;
                    end else begin
                        tmr <= tmr_inc;
                    end
                end
                FIN: begin
                    DONE  <= GNT;
                    GNT   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Receive path runs independently of the transmit FSM; gnt_idx keeps the last owner while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_ready_q <= 1'b0;
            RX_VALID    <= 1'b0;
            RX_DATA     <= '0;
            RX_ID       <= '0;
        end else begin
            out_ready_q <= ENG_OUT_READY;
            RX_VALID    <= ENG_OUT_READY & ~out_ready_q;
            if (ENG_OUT_READY && !out_ready_q) begin
                RX_DATA <= ENG_D_OUT;
                RX_ID   <= gnt_idx;
            end
        end
    end

endmodule

// File: tb/tb_iic_txn_scheduler.sv
// Self-checking bench for iic_txn_scheduler with a behavioural engine and per-requester word queues.
module tb_iic_txn_scheduler;

    localparam int WW = 8;
    localparam int NR = 4;
    localparam int LW = 4;
    localparam int TO = 15;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   REQ = '0;
    logic [NR*LW-1:0] REQ_LEN = '0;
    logic [NR-1:0]   TX_VALID;
    logic [NR*WW-1:0] TX_DATA;
    logic [NR-1:0]   TX_READY;
    logic [NR-1:0]   GNT;
    logic [NR-1:0]   DONE;
    logic            ERR;
    logic [WW-1:0]   RX_DATA;
    logic            RX_VALID;
    logic [1:0]      RX_ID;
    logic            ENG_WE;
    logic [WW-1:0]   ENG_D_IN;
    logic            ENG_IN_READY;
    logic [WW-1:0]   ENG_D_OUT = '0;
    logic            ENG_OUT_READY = 1'b0;

    iic_txn_scheduler #(.word_width(WW), .n_req(NR), .len_width(LW), .timeout(TO)) dut (
        .clk(clk), .rst(rst), .REQ(REQ), .REQ_LEN(REQ_LEN), .TX_VALID(TX_VALID),
        .TX_DATA(TX_DATA), .TX_READY(TX_READY), .GNT(GNT), .DONE(DONE), .ERR(ERR),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_ID(RX_ID), .ENG_WE(ENG_WE),
        .ENG_D_IN(ENG_D_IN), .ENG_IN_READY(ENG_IN_READY), .ENG_D_OUT(ENG_D_OUT),
        .ENG_OUT_READY(ENG_OUT_READY)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Engine model: busy for 10 cycles after each write, or forever while stuck.
    int   eng_busy = 0;
    logic eng_stuck = 1'b0;
    assign ENG_IN_READY = (eng_busy == 0);

    logic [WW-1:0] txw [NR][16];
    int txn [NR] = '{default: 0};
    int txh [NR] = '{default: 0};

    always_comb begin
        TX_VALID = '0;
        TX_DATA  = '0;
        for (int i = 0; i < NR; i++) begin
            TX_VALID[i]         = (txh[i] < txn[i]);
            TX_DATA[i*WW +: WW] = txw[i][txh[i] % 16];
        end
    end

    int we_cnt = 0, err_cnt = 0, gnt_cnt = 0, overlap_cnt = 0, rx_cnt = 0;
    int done_cnt [NR] = '{default: 0};
    logic [WW-1:0] we_log [64];
    int gnt_log [32];
    logic [NR-1:0] prev_gnt = '0;

    function automatic int onehot_idx(input logic [NR-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NR; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Monitors, engine and requester queues all sample on the falling edge.
    always @(negedge clk) begin
        if (ENG_WE) begin
            we_log[we_cnt % 64] = ENG_D_IN;
            we_cnt++;
            eng_busy = 10;
        end else if (eng_busy > 0 && !eng_stuck) begin
            eng_busy--;
        end
        for (int i = 0; i < NR; i++) begin
            if (DONE[i]) done_cnt[i]++;
            if (TX_READY[i]) txh[i]++;
        end
        if (ERR) err_cnt++;
        if (RX_VALID) rx_cnt++;
        if ($countones(GNT) > 1 || $countones(DONE) > 1 || $countones(TX_READY) > 1) overlap_cnt++;
        if (GNT != '0 && prev_gnt == '0) begin
            gnt_log[gnt_cnt % 32] = onehot_idx(GNT);
            gnt_cnt++;
        end
        prev_gnt = GNT;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_total++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic push_word(input int r, input logic [WW-1:0] w);
        txw[r][txn[r] % 16] = w;
        txn[r]++;
    endtask

    task automatic wait_done(input int r, input int d0, input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 300 && seen == 0; c++) begin
            tick(1);
            if (done_cnt[r] > d0) seen = 1;
        end
        check_output(name, seen, 1);
    endtask

    task automatic wait_we(input string name);
        int seen;
        seen = 0;
        for (int c = 0; c < 100 && seen == 0; c++) begin
            tick(1);
            if (ENG_WE) seen = 1;
        end
        check_output(name, seen, 1);
    endtask

    typedef struct {
        int          req;
        logic [3:0]  len;
        logic [23:0] words;
        logic [3:0]  exp_gnt;
        int          exp_we;
        logic [23:0] exp_d;
    } vec_t;

    task automatic apply_stimulus(input vec_t v, input int n);
        int we0, d0, e0;
        we0 = we_cnt;
        d0  = done_cnt[v.req];
        e0  = err_cnt;
        for (int j = 0; j < int'(v.len); j++) push_word(v.req, v.words[j*8 +: 8]);
        REQ_LEN[v.req*LW +: LW] = v.len;
        REQ[v.req] = 1'b1;
        tick(1);
        check_output($sformatf("v%0d_gnt_early", n), GNT, 0);
        tick(1);
        check_output($sformatf("v%0d_gnt", n), GNT, v.exp_gnt);
        REQ = '0;
        wait_done(v.req, d0, $sformatf("v%0d_done_seen", n));
        tick(2);
        check_output($sformatf("v%0d_done_count", n), done_cnt[v.req] - d0, 1);
        check_output($sformatf("v%0d_err", n), err_cnt - e0, 0);
        check_output($sformatf("v%0d_gnt_cleared", n), GNT, 0);
        check_output($sformatf("v%0d_we_count", n), we_cnt - we0, v.exp_we);
        for (int j = 0; j < v.exp_we; j++)
            check_output($sformatf("v%0d_d_in%0d", n, j), we_log[(we0 + j) % 64], v.exp_d[j*8 +: 8]);
    endtask

    vec_t vecs [4];

    initial begin
        int d0, d1, e0, g0, r0;
        logic early;

        vecs[0] = '{0, 4'd3, 24'hFF3CA5, 4'b0001, 3, 24'hFF3CA5};
        vecs[1] = '{2, 4'd0, 24'h000000, 4'b0100, 0, 24'h000000};
        vecs[2] = '{3, 4'd1, 24'h000081, 4'b1000, 1, 24'h000081};
        vecs[3] = '{1, 4'd2, 24'h003412, 4'b0010, 2, 24'h003412};

        tick(3);
        check_output("rst_gnt", GNT, 0);
        check_output("rst_done", DONE, 0);
        check_output("rst_err", ERR, 0);
        check_output("rst_tx_ready", TX_READY, 0);
        check_output("rst_eng_we", ENG_WE, 0);
        check_output("rst_eng_d_in", ENG_D_IN, 0);
        check_output("rst_rx", {RX_VALID, RX_ID, RX_DATA}, 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            apply_stimulus(vecs[i], i);
            tick(3);
        end

        // All four requesting with LEN=1 from a fresh pointer: grants go 0,1,2,3,0.
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        g0 = gnt_cnt;
        d0 = done_cnt[0];
        for (int i = 0; i < NR; i++) push_word(i, 8'h10 + 8'(i));
        push_word(0, 8'h20);
        REQ_LEN = {4'd1, 4'd1, 4'd1, 4'd1};
        REQ = 4'b1111;
        for (int c = 0; c < 400 && gnt_cnt < g0 + 5; c++) tick(1);
        REQ = '0;
        check_output("rr_grants_seen", gnt_cnt - g0, 5);
        check_output("rr_order0", gnt_log[(g0 + 0) % 32], 0);
        check_output("rr_order1", gnt_log[(g0 + 1) % 32], 1);
        check_output("rr_order2", gnt_log[(g0 + 2) % 32], 2);
        check_output("rr_order3", gnt_log[(g0 + 3) % 32], 3);
        check_output("rr_order4", gnt_log[(g0 + 4) % 32], 0);
        for (int c = 0; c < 300 && done_cnt[0] < d0 + 2; c++) tick(1);
        check_output("rr_req0_done_twice", done_cnt[0] - d0, 2);
        tick(3);

        // Engine never returns to idle after the write: abort decided when tmr reaches 15.
        d0 = done_cnt[0];
        e0 = err_cnt;
        push_word(0, 8'hC3);
        REQ_LEN[3:0] = 4'd1;
        REQ[0] = 1'b1;
        wait_we("to_we_seen");
        eng_stuck = 1'b1;
        REQ = '0;
        early = 1'b0;
        for (int c = 1; c <= TO; c++) begin
            tick(1);
            if (ERR || DONE != '0) early = 1'b1;
        end
        check_output("to_no_early_abort", early, 0);
        tick(1);
        check_output("to_err_pulse", ERR, 1);
        check_output("to_done_pulse", DONE, 4'b0001);
        check_output("to_gnt_cleared", GNT, 0);
        tick(1);
        check_output("to_err_one_cycle", {ERR, DONE}, 0);
        eng_stuck = 1'b0;
        check_output("to_err_count", err_cnt - e0, 1);
        check_output("to_done_count", done_cnt[0] - d0, 1);
        tick(15);

        // Reset while the engine is busy with the first of two words.
        d0 = done_cnt[0];
        e0 = err_cnt;
        push_word(0, 8'h66);
        push_word(0, 8'h99);
        REQ_LEN[3:0] = 4'd2;
        REQ[0] = 1'b1;
        wait_we("rw_we_seen");
        REQ = '0;
        tick(3);
        rst = 1'b1;
        tick(1);
        check_output("rw_gnt", GNT, 0);
        check_output("rw_strobes", {DONE, ERR, TX_READY, ENG_WE, RX_VALID}, 0);
        check_output("rw_d_in", ENG_D_IN, 0);
        rst = 1'b0;
        tick(20);
        check_output("rw_no_done", done_cnt[0] - d0, 0);
        check_output("rw_no_err", err_cnt - e0, 0);
        check_output("rw_gnt_idle", GNT, 0);
        REQ_LEN = {4'd1, 4'd1, 4'd1, 4'd1};
        REQ = 4'b1111;
        tick(2);
        check_output("rw_rr_restart", GNT, 4'b0001);
        REQ = '0;
        wait_done(0, d0, "rw_leftover_done");
        tick(3);

        // Receive word while requester 1 owns the engine.
        d1 = done_cnt[1];
        push_word(1, 8'h77);
        REQ_LEN[7:4] = 4'd1;
        REQ[1] = 1'b1;
        tick(2);
        check_output("rx_gnt1", GNT, 4'b0010);
        REQ = '0;
        r0 = rx_cnt;
        ENG_D_OUT = 8'h5A;
        ENG_OUT_READY = 1'b1;
        tick(1);
        check_output("rx_valid", RX_VALID, 1);
        check_output("rx_data", RX_DATA, 8'h5A);
        check_output("rx_id", RX_ID, 1);
        tick(1);
        check_output("rx_valid_one_cycle", RX_VALID, 0);
        ENG_OUT_READY = 1'b0;
        tick(3);
        check_output("rx_count", rx_cnt - r0, 1);
        wait_done(1, d1, "rx_txn_done");
        tick(3);

        check_output("no_overlap", overlap_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
